// File: rtl/quire_window_arbiter_pkg.sv
// Shared posit/quire definitions for the quire window arbiter slice.
// Holds the quire width helper and the posit<4,0> quire width constant.
// Imported by the arbiter top; contains no logic of its own.
package quire_window_arbiter_pkg;

   // Quire width for posit<n,es>:
   // 2^(es+2)*(n-2) bits of fixed-point range, one sign bit, and
   // log_acc carry-guard bits for accumulating 2^log_acc products.
   function automatic int quire_width(input int n, input int es, input int log_acc);
      return (1 << (es + 2)) * (n - 2) + 1 + log_acc;
   endfunction

   // posit<4,0> with 10 carry-guard bits -> 19-bit quire.
   localparam int QUIRE_W_4_0 = quire_width(4, 0, 10);

endpackage

// File: rtl/quire_window_arbiter_id_fifo.sv
// Purpose: synchronous FIFO holding the requester IDs of outstanding windows.
// Ports: clk/rst_n (async active-low); push/din write, pop read; full/empty/head status.
// Latency: head is valid combinationally from storage; push and pop may share a cycle.
module quire_window_arbiter_id_fifo #(
   parameter int W     = 2,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   // One extra pointer bit distinguishes full from empty.
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic         do_push;
   logic         do_pop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = mem[rd_ptr[AW-1:0]];

   // A push while full is accepted only if the head leaves in the same cycle.
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/quire_window_arbiter.sv
// Purpose: round-robin window arbiter sharing one quire between NUM_REQ product
//   streams; forwards granted beats and returns only eow results tagged with owner ID.
// Ports: req_* per-lane beat handshake/payload; q_* beat to quire; q_res_* quire
//   results in; res_* tagged final results out; err_o sticky protocol error.
// Latency: 1 cycle sow-to-grant, beat and result paths combinational, one idle
//   bubble between windows. Backpressure: q_rtr_i holds the granted lane,
//   res_rtr_i stalls eow results; no grant while the ID FIFO is full.
module quire_window_arbiter
   import quire_window_arbiter_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int FRAC_W   = 4,
   parameter int SCALE_W  = 3,
   parameter int QUIRE_W  = QUIRE_W_4_0,
   parameter int ID_DEPTH = 4,
   parameter int ID_W     = $clog2(NUM_REQ)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   // requester side
   input  logic [NUM_REQ-1:0]         req_rts_i,
   output logic [NUM_REQ-1:0]         req_rtr_o,
   input  logic [NUM_REQ-1:0]         req_sow_i,
   input  logic [NUM_REQ-1:0]         req_eow_i,
   input  logic [NUM_REQ-1:0]         req_sign_i,
   input  logic [NUM_REQ-1:0]         req_zero_i,
   input  logic [NUM_REQ-1:0]         req_nar_i,
   input  logic [NUM_REQ*FRAC_W-1:0]  req_fraction_i,
   input  logic [NUM_REQ*SCALE_W-1:0] req_scale_i,
   // quire slave side (beats into the quire)
   output logic                       q_rts_o,
   input  logic                       q_rtr_i,
   output logic                       q_sow_o,
   output logic                       q_eow_o,
   output logic                       q_sign_o,
   output logic                       q_zero_o,
   output logic                       q_nar_o,
   output logic [FRAC_W-1:0]          q_fraction_o,
   output logic [SCALE_W-1:0]         q_scale_o,
   // quire master side (results out of the quire)
   input  logic                       q_res_rts_i,
   output logic                       q_res_rtr_o,
   input  logic                       q_res_eow_i,
   input  logic                       q_res_nar_i,
   input  logic                       q_res_zero_i,
   input  logic [QUIRE_W-1:0]         q_res_data_i,
   // tagged final results
   output logic                       res_rts_o,
   input  logic                       res_rtr_i,
   output logic [QUIRE_W-1:0]         res_data_o,
   output logic [ID_W-1:0]            res_id_o,
   output logic                       res_nar_o,
   output logic                       res_zero_o,
   output logic                       err_o
);

   typedef enum logic {IDLE, LOCKED} arb_state_t;

   arb_state_t         state;
   logic [ID_W-1:0]    grant;
   logic [ID_W-1:0]    last;
   logic               first_beat;
   logic               err;

   logic [NUM_REQ-1:0] cand;
   logic [NUM_REQ-1:0] stray;
   logic [ID_W-1:0]    next_grant;

   logic               sel_rts;
   logic               sel_sow;
   logic               sel_eow;
   logic               sel_sign;
   logic               sel_zero;
   logic               sel_nar;
   logic [FRAC_W-1:0]  sel_frac;
   logic [SCALE_W-1:0] sel_scale;

   logic               beat_xfer;
   logic               stray_xfer;
   logic               sow_err;
   logic               res_eow_vld;
   logic               orphan;

   logic               fifo_push;
   logic               fifo_pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [ID_W-1:0]    fifo_head;

   // First set bit of c searching upward from l+1, wrapping; returns l if none.
   function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] c,
                                               input logic [ID_W-1:0]    l);
      logic [ID_W-1:0] p;
      logic            found;
      int              idx;
      p     = l;
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(l) + k) % NUM_REQ;
         if (!found && c[idx]) begin
            p     = ID_W'(idx);
            found = 1'b1;
         end
      end
      return p;
   endfunction

   assign cand       = req_rts_i & req_sow_i;
   assign stray      = req_rts_i & ~req_sow_i;
   assign next_grant = rr_pick(cand, last);

   // Granted-lane payload mux.
   always_comb begin
      sel_rts   = 1'b0;
      sel_sow   = 1'b0;
      sel_eow   = 1'b0;
      sel_sign  = 1'b0;
      sel_zero  = 1'b0;
      sel_nar   = 1'b0;
      sel_frac  = '0;
      sel_scale = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant == ID_W'(i)) begin
            sel_rts   = req_rts_i[i];
            sel_sow   = req_sow_i[i];
            sel_eow   = req_eow_i[i];
            sel_sign  = req_sign_i[i];
            sel_zero  = req_zero_i[i];
            sel_nar   = req_nar_i[i];
            sel_frac  = req_fraction_i[i*FRAC_W +: FRAC_W];
            sel_scale = req_scale_i[i*SCALE_W +: SCALE_W];
         end
      end
   end

   // In IDLE, beats without sow are swallowed so a misbehaving lane cannot
   // wedge itself; in LOCKED only the granted lane sees the quire's ready.
   always_comb begin
      req_rtr_o = '0;
      if (state == IDLE) begin
         req_rtr_o = stray;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            req_rtr_o[i] = (grant == ID_W'(i)) && q_rtr_i;
         end
      end
   end

   assign q_rts_o      = (state == LOCKED) && sel_rts;
   assign q_sow_o      = sel_sow;
   assign q_eow_o      = sel_eow;
   assign q_sign_o     = sel_sign;
   assign q_zero_o     = sel_zero;
   assign q_nar_o      = sel_nar;
   assign q_fraction_o = sel_frac;
   assign q_scale_o    = sel_scale;

   assign beat_xfer  = q_rts_o && q_rtr_i;
   assign stray_xfer = (state == IDLE) && (|stray);
   assign sow_err    = beat_xfer && sel_sow && !first_beat;
   assign fifo_push  = (state == IDLE) && (|cand) && !fifo_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         grant      <= '0;
         last       <= ID_W'(NUM_REQ - 1);
         first_beat <= 1'b0;
         err        <= 1'b0;
      end else begin
         if (stray_xfer || sow_err || orphan) err <= 1'b1;
         case (state)
            IDLE: begin
               if (fifo_push) begin
                  grant      <= next_grant;
                  first_beat <= 1'b1;
                  state      <= LOCKED;
               end
            end
            LOCKED: begin
               if (beat_xfer) begin
                  first_beat <= 1'b0;
                  if (sel_eow) begin
                     last  <= grant;
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign err_o = err;

   // Result side: partial sums are consumed and dropped; eow results are
   // forwarded with the oldest outstanding window ID. An eow result with no
   // outstanding window is dropped and flagged.
   assign res_eow_vld = q_res_rts_i && q_res_eow_i;
   assign orphan      = res_eow_vld && fifo_empty;
   assign res_rts_o   = res_eow_vld && !fifo_empty;
   assign q_res_rtr_o = !q_res_eow_i || fifo_empty || res_rtr_i;
   assign fifo_pop    = res_rts_o && res_rtr_i;

   assign res_data_o  = q_res_data_i;
   assign res_nar_o   = q_res_nar_i;
   assign res_zero_o  = q_res_zero_i;
   assign res_id_o    = fifo_head;

   quire_window_arbiter_id_fifo #(
      .W     (ID_W),
      .DEPTH (ID_DEPTH)
   ) u_id_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .din   (next_grant),
      .pop   (fifo_pop),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

endmodule

// File: tb/tb_quire_window_arbiter.sv
// Purpose: directed self-checking bench for quire_window_arbiter.
// Ports: none; drives all DUT ports, inputs change #1 after posedge, outputs sampled on negedge.
// Scenarios: reset, single window, contention, fairness, FIFO full, protocol error, single-beat NaR.
module tb_quire_window_arbiter;

   localparam int NUM_REQ  = 4;
   localparam int FRAC_W   = 4;
   localparam int SCALE_W  = 3;
   localparam int QUIRE_W  = 19;
   localparam int ID_DEPTH = 4;
   localparam int ID_W     = 2;

   logic                       clk;
   logic                       rst_n;
   logic [NUM_REQ-1:0]         req_rts;
   logic [NUM_REQ-1:0]         req_rtr;
   logic [NUM_REQ-1:0]         req_sow;
   logic [NUM_REQ-1:0]         req_eow;
   logic [NUM_REQ-1:0]         req_sign;
   logic [NUM_REQ-1:0]         req_zero;
   logic [NUM_REQ-1:0]         req_nar;
   logic [NUM_REQ*FRAC_W-1:0]  req_fraction;
   logic [NUM_REQ*SCALE_W-1:0] req_scale;
   logic                       q_rts;
   logic                       q_rtr;
   logic                       q_sow;
   logic                       q_eow;
   logic                       q_sign;
   logic                       q_zero;
   logic                       q_nar;
   logic [FRAC_W-1:0]          q_fraction;
   logic [SCALE_W-1:0]         q_scale;
   logic                       q_res_rts;
   logic                       q_res_rtr;
   logic                       q_res_eow;
   logic                       q_res_nar;
   logic                       q_res_zero;
   logic [QUIRE_W-1:0]         q_res_data;
   logic                       res_rts;
   logic                       res_rtr;
   logic [QUIRE_W-1:0]         res_data;
   logic [ID_W-1:0]            res_id;
   logic                       res_nar;
   logic                       res_zero;
   logic                       err;

   int n_checks = 0;
   int n_fail   = 0;
   int res_xfers = 0;

   quire_window_arbiter #(
      .NUM_REQ (NUM_REQ), .FRAC_W (FRAC_W), .SCALE_W (SCALE_W),
      .QUIRE_W (QUIRE_W), .ID_DEPTH (ID_DEPTH), .ID_W (ID_W)
   ) dut (
      .clk (clk), .rst_n (rst_n),
      .req_rts_i (req_rts), .req_rtr_o (req_rtr), .req_sow_i (req_sow),
      .req_eow_i (req_eow), .req_sign_i (req_sign), .req_zero_i (req_zero),
      .req_nar_i (req_nar), .req_fraction_i (req_fraction), .req_scale_i (req_scale),
      .q_rts_o (q_rts), .q_rtr_i (q_rtr), .q_sow_o (q_sow), .q_eow_o (q_eow),
      .q_sign_o (q_sign), .q_zero_o (q_zero), .q_nar_o (q_nar),
      .q_fraction_o (q_fraction), .q_scale_o (q_scale),
      .q_res_rts_i (q_res_rts), .q_res_rtr_o (q_res_rtr), .q_res_eow_i (q_res_eow),
      .q_res_nar_i (q_res_nar), .q_res_zero_i (q_res_zero), .q_res_data_i (q_res_data),
      .res_rts_o (res_rts), .res_rtr_i (res_rtr), .res_data_o (res_data),
      .res_id_o (res_id), .res_nar_o (res_nar), .res_zero_o (res_zero),
      .err_o (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count final-result transfers.
   always @(posedge clk) begin
      if (res_rts && res_rtr) res_xfers++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req_rts = '0; req_sow = '0; req_eow = '0; req_sign = '0; req_zero = '0;
      req_nar = '0; req_fraction = '0; req_scale = '0;
      q_rtr = 1'b0; q_res_rts = 1'b0; q_res_eow = 1'b0; q_res_nar = 1'b0;
      q_res_zero = 1'b0; q_res_data = '0; res_rtr = 1'b0;
   endtask

   task automatic set_lane(input int i, input logic rts, input logic sow, input logic eow,
                           input logic nar, input logic [FRAC_W-1:0] frac,
                           input logic [SCALE_W-1:0] scale);
      req_rts[i] = rts; req_sow[i] = sow; req_eow[i] = eow; req_nar[i] = nar;
      req_sign[i] = 1'b0; req_zero[i] = 1'b0;
      req_fraction[i*FRAC_W +: FRAC_W] = frac;
      req_scale[i*SCALE_W +: SCALE_W]  = scale;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clear_inputs();
      #2;
      n_checks++; if (q_rts !== 1'b0) begin n_fail++; $display("FAIL reset_q_rts: got %b want 0", q_rts); end
      n_checks++; if (res_rts !== 1'b0) begin n_fail++; $display("FAIL reset_res_rts: got %b want 0", res_rts); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
      n_checks++; if (req_rtr !== 4'b0000) begin n_fail++; $display("FAIL reset_req_rtr: got %b want 0000", req_rtr); end
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_single_window();
      int x0;
      do_reset();
      q_rtr = 1'b1; res_rtr = 1'b1;
      x0 = res_xfers;
      set_lane(1, 1, 1, 0, 0, 4'h3, 3'h1);
      @(negedge clk);
      n_checks++; if (q_rts !== 1'b0) begin n_fail++; $display("FAIL sw_idle_q_rts: got %b want 0", q_rts); end
      n_checks++; if (req_rtr !== 4'b0000) begin n_fail++; $display("FAIL sw_idle_rtr: got %b want 0000", req_rtr); end
      step();
      @(negedge clk);
      n_checks++; if (q_rts !== 1'b1) begin n_fail++; $display("FAIL sw_grant_q_rts: got %b want 1", q_rts); end
      n_checks++; if (req_rtr !== 4'b0010) begin n_fail++; $display("FAIL sw_grant_rtr: got %b want 0010", req_rtr); end
      n_checks++; if (q_sow !== 1'b1 || q_fraction !== 4'h3) begin n_fail++; $display("FAIL sw_beat0: got sow=%b frac=%h want sow=1 frac=3", q_sow, q_fraction); end
      step();
      set_lane(1, 1, 0, 0, 0, 4'h5, 3'h2);
      @(negedge clk);
      n_checks++; if (q_fraction !== 4'h5 || q_scale !== 3'h2) begin n_fail++; $display("FAIL sw_beat1: got frac=%h scale=%h want 5 2", q_fraction, q_scale); end
      step();
      set_lane(1, 1, 0, 1, 0, 4'h7, 3'h6);
      @(negedge clk);
      n_checks++; if (q_eow !== 1'b1 || q_rts !== 1'b1) begin n_fail++; $display("FAIL sw_beat2: got eow=%b rts=%b want 1 1", q_eow, q_rts); end
      step();
      set_lane(1, 0, 0, 0, 0, 4'h0, 3'h0);
      q_res_rts = 1'b1; q_res_eow = 1'b0; q_res_data = 19'd5;
      @(negedge clk);
      n_checks++; if (q_rts !== 1'b0) begin n_fail++; $display("FAIL sw_back_idle: got %b want 0", q_rts); end
      n_checks++; if (q_res_rtr !== 1'b1 || res_rts !== 1'b0) begin n_fail++; $display("FAIL sw_partial_drop: got rtr=%b rts=%b want 1 0", q_res_rtr, res_rts); end
      step();
      q_res_data = 19'd9;
      step();
      q_res_data = 19'd12; q_res_eow = 1'b1;
      @(negedge clk);
      n_checks++; if (res_rts !== 1'b1 || res_data !== 19'd12 || res_id !== 2'd1) begin n_fail++; $display("FAIL sw_final: got rts=%b data=%0d id=%0d want 1 12 1", res_rts, res_data, res_id); end
      step();
      q_res_rts = 1'b0; q_res_eow = 1'b0;
      @(negedge clk);
      n_checks++; if (res_xfers - x0 !== 1) begin n_fail++; $display("FAIL sw_xfer_count: got %0d want 1", res_xfers - x0); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL sw_err: got %b want 0", err); end
   endtask

   task automatic test_contention();
      do_reset();
      q_rtr = 1'b1; res_rtr = 1'b1;
      set_lane(0, 1, 1, 0, 0, 4'hA, 3'h0);
      set_lane(2, 1, 1, 1, 0, 4'hC, 3'h0);
      step();
      @(negedge clk);
      n_checks++; if (req_rtr !== 4'b0001 || q_fraction !== 4'hA) begin n_fail++; $display("FAIL ct_first_grant: got rtr=%b frac=%h want 0001 a", req_rtr, q_fraction); end
      step();
      set_lane(0, 1, 0, 1, 0, 4'hB, 3'h0);
      @(negedge clk);
      n_checks++; if (req_rtr !== 4'b0001 || q_eow !== 1'b1) begin n_fail++; $display("FAIL ct_lane0_eow: got rtr=%b eow=%b want 0001 1", req_rtr, q_eow); end
      step();
      set_lane(0, 0, 0, 0, 0, 4'h0, 3'h0);
      @(negedge clk);
      n_checks++; if (q_rts !== 1'b0 || req_rtr !== 4'b0000) begin n_fail++; $display("FAIL ct_bubble: got rts=%b rtr=%b want 0 0000", q_rts, req_rtr); end
      step();
      @(negedge clk);
      n_checks++; if (q_rts !== 1'b1 || req_rtr !== 4'b0100 || q_fraction !== 4'hC) begin n_fail++; $display("FAIL ct_second_grant: got rts=%b rtr=%b frac=%h want 1 0100 c", q_rts, req_rtr, q_fraction); end
      step();
      set_lane(2, 0, 0, 0, 0, 4'h0, 3'h0);
      q_res_rts = 1'b1; q_res_eow = 1'b1; q_res_data = 19'd1;
      @(negedge clk);
      n_checks++; if (res_rts !== 1'b1 || res_id !== 2'd0) begin n_fail++; $display("FAIL ct_id0: got rts=%b id=%0d want 1 0", res_rts, res_id); end
      step();
      @(negedge clk);
      n_checks++; if (res_rts !== 1'b1 || res_id !== 2'd2) begin n_fail++; $display("FAIL ct_id2: got rts=%b id=%0d want 1 2", res_rts, res_id); end
      step();
      q_res_rts = 1'b0; q_res_eow = 1'b0;
      @(negedge clk);
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL ct_err: got %b want 0", err); end
   endtask

   task automatic test_fairness();
      logic [3:0] exp_rtr;
      logic [1:0] exp_id;
      do_reset();
      q_rtr = 1'b1; res_rtr = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) set_lane(i, 1, 1, 1, 0, FRAC_W'(i + 8), 3'h0);
      for (int k = 0; k < 5; k++) begin
         exp_id  = 2'(k % 4);
         exp_rtr = 4'b0001 << exp_id;
         step();
         q_res_rts = 1'b1; q_res_eow = 1'b1; q_res_data = 19'(k);
         @(negedge clk);
         n_checks++; if (req_rtr !== exp_rtr || q_fraction !== 4'(exp_id + 8)) begin n_fail++; $display("FAIL fair_grant_%0d: got rtr=%b frac=%h want %b %h", k, req_rtr, q_fraction, exp_rtr, 4'(exp_id + 8)); end
         n_checks++; if (res_rts !== 1'b1 || res_id !== exp_id) begin n_fail++; $display("FAIL fair_id_%0d: got rts=%b id=%0d want 1 %0d", k, res_rts, res_id, exp_id); end
         step();
         q_res_rts = 1'b0; q_res_eow = 1'b0;
         @(negedge clk);
         n_checks++; if (q_rts !== 1'b0) begin n_fail++; $display("FAIL fair_bubble_%0d: got %b want 0", k, q_rts); end
      end
      clear_inputs();
      @(negedge clk);
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL fair_err: got %b want 0", err); end
   endtask

   task automatic test_fifo_full();
      do_reset();
      q_rtr = 1'b1; res_rtr = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) set_lane(i, 1, 1, 1, 0, 4'h1, 3'h0);
      repeat (8) step();
      @(negedge clk);
      n_checks++; if (q_rts !== 1'b0) begin n_fail++; $display("FAIL ff_no_grant_a: got %b want 0", q_rts); end
      step();
      q_res_rts = 1'b1; q_res_eow = 1'b1; q_res_data = 19'd3;
      @(negedge clk);
      n_checks++; if (q_rts !== 1'b0 || req_rtr !== 4'b0000) begin n_fail++; $display("FAIL ff_no_grant_b: got rts=%b rtr=%b want 0 0000", q_rts, req_rtr); end
      n_checks++; if (res_rts !== 1'b1 || res_id !== 2'd0 || q_res_rtr !== 1'b0) begin n_fail++; $display("FAIL ff_stall: got rts=%b id=%0d qrtr=%b want 1 0 0", res_rts, res_id, q_res_rtr); end
      step();
      @(negedge clk);
      n_checks++; if (res_id !== 2'd0 || res_data !== 19'd3 || q_rts !== 1'b0) begin n_fail++; $display("FAIL ff_hold: got id=%0d data=%0d rts=%b want 0 3 0", res_id, res_data, q_rts); end
      step();
      res_rtr = 1'b1;
      @(negedge clk);
      n_checks++; if (q_res_rtr !== 1'b1) begin n_fail++; $display("FAIL ff_release: got %b want 1", q_res_rtr); end
      step();
      res_rtr = 1'b0; q_res_rts = 1'b0; q_res_eow = 1'b0;
      @(negedge clk);
      n_checks++; if (q_rts !== 1'b0 || res_id !== 2'd1) begin n_fail++; $display("FAIL ff_after_pop: got rts=%b head=%0d want 0 1", q_rts, res_id); end
      step();
      @(negedge clk);
      n_checks++; if (q_rts !== 1'b1 || req_rtr !== 4'b0001) begin n_fail++; $display("FAIL ff_regrant: got rts=%b rtr=%b want 1 0001", q_rts, req_rtr); end
      step();
      clear_inputs();
   endtask

   task automatic test_protocol_error();
      do_reset();
      @(negedge clk);
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL pe_err_clear: got %b want 0", err); end
      set_lane(3, 1, 0, 0, 0, 4'h2, 3'h0);
      @(negedge clk);
      n_checks++; if (req_rtr !== 4'b1000 || q_rts !== 1'b0) begin n_fail++; $display("FAIL pe_discard: got rtr=%b rts=%b want 1000 0", req_rtr, q_rts); end
      step();
      set_lane(3, 0, 0, 0, 0, 4'h0, 3'h0);
      @(negedge clk);
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL pe_err_set: got %b want 1", err); end
      repeat (3) step();
      @(negedge clk);
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL pe_err_sticky: got %b want 1", err); end
      do_reset();
      @(negedge clk);
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL pe_err_reset: got %b want 0", err); end
   endtask

   task automatic test_single_beat_nar();
      do_reset();
      q_rtr = 1'b1; res_rtr = 1'b1;
      set_lane(2, 1, 1, 1, 1, 4'h0, 3'h0);
      step();
      @(negedge clk);
      n_checks++; if (q_rts !== 1'b1 || q_nar !== 1'b1 || q_eow !== 1'b1 || req_rtr !== 4'b0100) begin n_fail++; $display("FAIL sb_beat: got rts=%b nar=%b eow=%b rtr=%b want 1 1 1 0100", q_rts, q_nar, q_eow, req_rtr); end
      step();
      q_res_rts = 1'b1; q_res_eow = 1'b1; q_res_nar = 1'b1; q_res_data = '0;
      @(negedge clk);
      n_checks++; if (q_rts !== 1'b0) begin n_fail++; $display("FAIL sb_idle: got %b want 0", q_rts); end
      n_checks++; if (res_rts !== 1'b1 || res_nar !== 1'b1 || res_id !== 2'd2) begin n_fail++; $display("FAIL sb_result: got rts=%b nar=%b id=%0d want 1 1 2", res_rts, res_nar, res_id); end
      step();
      clear_inputs();
      @(negedge clk);
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL sb_err: got %b want 0", err); end
   endtask

   initial begin
      test_reset();
      test_single_window();
      test_contention();
      test_fairness();
      test_fifo_full();
      test_protocol_error();
      test_single_beat_nar();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
